// File: rtl/tennis_score_display.sv
// Scoreboard display driver: latches two player scores and scans them, with a
// winner banner and blinking winner score, onto a common-anode 7-segment bank.
module tennis_score_display #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCORE_W      = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64,
   parameter int WIN_SCORE    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SCORE_W-1:0]    p0,
   input  logic [SCORE_W-1:0]    p1,
   input  logic                  score_valid,
   input  logic                  clr,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [6:0]            seg_n,
   output logic                  frame_tick
);
   localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int H     = NUM_DIGITS / 2;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_P     = 7'b0001100;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   logic [PS_W-1:0]       r_presc;
   logic [IDX_W-1:0]      r_idx;
   logic [FC_W-1:0]       r_fcnt;
   logic                  r_phase;
   logic [SCORE_W-1:0]    r_s0;
   logic [SCORE_W-1:0]    r_s1;
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;
   logic                  r_ftick;

   logic       w_tc;
   logic       w_wrap;
   logic [6:0] w_s0;
   logic [6:0] w_s1;
   logic [6:0] w_d0;
   logic [6:0] w_d1;
   logic [3:0] w_s0_t;
   logic [3:0] w_s0_o;
   logic [3:0] w_s1_t;
   logic [3:0] w_s1_o;
   logic       w_win0;
   logic       w_win1;
   logic       w_blank0;
   logic       w_blank1;
   logic       w_drive;
   logic [6:0] w_glyph;

   function automatic logic [6:0] f_glyph(input logic [3:0] v);
      case (v)
         4'd0:    f_glyph = 7'b1000000;
         4'd1:    f_glyph = 7'b1111001;
         4'd2:    f_glyph = 7'b0100100;
         4'd3:    f_glyph = 7'b0110000;
         4'd4:    f_glyph = 7'b0011001;
         4'd5:    f_glyph = 7'b0010010;
         4'd6:    f_glyph = 7'b0000010;
         4'd7:    f_glyph = 7'b1111000;
         4'd8:    f_glyph = 7'b0000000;
         4'd9:    f_glyph = 7'b0010000;
         default: f_glyph = SEG_BLANK;
      endcase
   endfunction

   assign w_tc   = (r_presc == PS_W'(REFRESH_DIV - 1));
   assign w_wrap = w_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));

   // Scores above 99 are held in full for winner detection but shown as 99.
   assign w_s0   = 7'(r_s0);
   assign w_s1   = 7'(r_s1);
   assign w_d0   = (w_s0 > 7'd99) ? 7'd99 : w_s0;
   assign w_d1   = (w_s1 > 7'd99) ? 7'd99 : w_s1;
   assign w_s0_t = 4'(w_d0 / 7'd10);
   assign w_s0_o = 4'(w_d0 % 7'd10);
   assign w_s1_t = 4'(w_d1 / 7'd10);
   assign w_s1_o = 4'(w_d1 % 7'd10);

   assign w_win0   = (w_s0 >= 7'(WIN_SCORE));
   assign w_win1   = (w_s1 >= 7'(WIN_SCORE));
   assign w_blank0 = w_win0 && !w_win1 && r_phase;
   assign w_blank1 = w_win1 && !w_win0 && r_phase;

   always_comb begin
      w_drive = 1'b0;
      w_glyph = SEG_BLANK;
      if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
         if (w_s0_t != 4'd0 && !w_blank0) begin
            w_drive = 1'b1;
            w_glyph = f_glyph(w_s0_t);
         end
      end else if (r_idx == IDX_W'(NUM_DIGITS - 2)) begin
         if (!w_blank0) begin
            w_drive = 1'b1;
            w_glyph = f_glyph(w_s0_o);
         end
      end else if (r_idx == IDX_W'(H)) begin
         if (w_win0 || w_win1) begin
            w_drive = 1'b1;
            w_glyph = (w_win0 && w_win1) ? SEG_DASH : SEG_P;
         end
      end else if (r_idx == IDX_W'(H - 1)) begin
         if (w_win0 || w_win1) begin
            w_drive = 1'b1;
            if (w_win0 && w_win1)
               w_glyph = SEG_DASH;
            else
               w_glyph = w_win0 ? f_glyph(4'd1) : f_glyph(4'd2);
         end
      end else if (r_idx == IDX_W'(1)) begin
         if (w_s1_t != 4'd0 && !w_blank1) begin
            w_drive = 1'b1;
            w_glyph = f_glyph(w_s1_t);
         end
      end else if (r_idx == IDX_W'(0)) begin
         if (!w_blank1) begin
            w_drive = 1'b1;
            w_glyph = f_glyph(w_s1_o);
         end
      end
   end

   // Scan engine: prescaler, digit index, frame counter and blink phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_fcnt  <= '0;
         r_phase <= 1'b0;
         r_ftick <= 1'b0;
      end else begin
         r_ftick <= w_wrap;
         if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_presc <= r_presc + PS_W'(1);
         end
         if (w_wrap) begin
            if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
               r_fcnt  <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_fcnt <= r_fcnt + FC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0 <= '0;
         r_s1 <= '0;
      end else if (clr) begin
         r_s0 <= '0;
         r_s1 <= '0;
      end else if (score_valid) begin
         r_s0 <= p0;
         r_s1 <= p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= '1;
         r_seg <= SEG_BLANK;
      end else begin
         r_an  <= w_drive ? ~(NUM_DIGITS'(1) << r_idx) : '1;
         r_seg <= w_glyph;
      end
   end

   assign an_n       = r_an;
   assign seg_n      = r_seg;
   assign frame_tick = r_ftick;
endmodule

// File: tb/tb_tennis_score_display.sv
// Bench for tennis_score_display: scoreboard of per-digit expectations for each
// scanned frame, plus reset, scan timing, saturation, clear and blink scenarios.
module tb_tennis_score_display;
   localparam int ND = 8;
   localparam int SW = 7;
   localparam int RD = 4;
   localparam int BF = 2;
   localparam int WS = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SW-1:0] p0 = '0;
   logic [SW-1:0] p1 = '0;
   logic          score_valid = 1'b0;
   logic          clr = 1'b0;
   logic [ND-1:0] an_n;
   logic [6:0]    seg_n;
   logic          frame_tick;

   int checks = 0;
   int errors = 0;
   int ticks  = 0;
   int m_s0   = 0;
   int m_s1   = 0;

   typedef struct {
      int         dig;
      logic [7:0] an;
      logic [6:0] seg;
   } exp_t;
   exp_t sb[$];

   tennis_score_display #(
      .NUM_DIGITS(ND), .SCORE_W(SW), .REFRESH_DIV(RD),
      .BLINK_FRAMES(BF), .WIN_SCORE(WS)
   ) dut (
      .clk(clk), .rst(rst), .p0(p0), .p1(p1), .score_valid(score_valid),
      .clr(clr), .an_n(an_n), .seg_n(seg_n), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   always @(negedge clk or posedge rst) begin
      if (rst) ticks = 0;
      else if (frame_tick) ticks = ticks + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic exp_t model(input int d, input int s0, input int s1, input int ph);
      exp_t e;
      int a0, a1;
      bit w0, w1, on;
      logic [6:0] g;
      logic [7:0] one;
      a0 = (s0 > 99) ? 99 : s0;
      a1 = (s1 > 99) ? 99 : s1;
      w0 = (s0 >= WS);
      w1 = (s1 >= WS);
      on = 1'b0;
      g  = 7'h7F;
      case (d)
         7: if (a0 / 10 != 0 && !(w0 && !w1 && ph == 1)) begin on = 1; g = glyph(a0 / 10); end
         6: if (!(w0 && !w1 && ph == 1)) begin on = 1; g = glyph(a0 % 10); end
         4: if (w0 && w1) begin on = 1; g = 7'b0111111; end
            else if (w0 || w1) begin on = 1; g = 7'b0001100; end
         3: if (w0 && w1) begin on = 1; g = 7'b0111111; end
            else if (w0) begin on = 1; g = glyph(1); end
            else if (w1) begin on = 1; g = glyph(2); end
         1: if (a1 / 10 != 0 && !(w1 && !w0 && ph == 1)) begin on = 1; g = glyph(a1 / 10); end
         0: if (!(w1 && !w0 && ph == 1)) begin on = 1; g = glyph(a1 % 10); end
         default: on = 0;
      endcase
      one   = 8'h01;
      e.dig = d;
      e.an  = on ? ~(one << d) : 8'hFF;
      e.seg = on ? g : 7'h7F;
      return e;
   endfunction

   task automatic latch(input int a, input int b, input bit c);
      @(negedge clk);
      p0 = SW'(a);
      p1 = SW'(b);
      score_valid = 1'b1;
      clr = c;
      @(negedge clk);
      score_valid = 1'b0;
      clr = 1'b0;
      if (c) begin m_s0 = 0; m_s1 = 0; end
      else begin m_s0 = a; m_s1 = b; end
   endtask

   // Align to the next frame start, queue the expected digits, then scan them.
   task automatic check_frame(input string nm);
      int n;
      int ph;
      exp_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 200);
      checks++;
      if (frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL %s frame_tick wait: got %b want 1", nm, frame_tick);
         return;
      end
      #1;
      ph = (ticks / BF) % 2;
      for (int d = 0; d < ND; d++) sb.push_back(model(d, m_s0, m_s1, ph));
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         e = sb.pop_front();
         checks++;
         if ({an_n, seg_n} !== {e.an, e.seg}) begin
            errors++;
            $display("FAIL %s digit %0d: got an_n=%h seg_n=%b want an_n=%h seg_n=%b",
                     nm, e.dig, an_n, seg_n, e.an, e.seg);
         end
         if (d < ND - 1) repeat (RD) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if (an_n !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", an_n); end
      checks++;
      if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg_n); end
      checks++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
      rst = 1'b0;
   endtask

   task automatic test_scan;
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 200);
      n = 0;
      @(negedge clk);
      n++;
      checks++;
      if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width got %b want 0", frame_tick); end
      while (frame_tick !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != ND * RD) begin errors++; $display("FAIL tick_period got %0d want %0d", n, ND * RD); end
      check_frame("scan_zero");
   endtask

   task automatic test_score;
      latch(2, 0, 0);
      check_frame("score_2_0");
   endtask

   task automatic test_blink;
      latch(3, 1, 0);
      repeat (4) check_frame("blink_p1");
   endtask

   task automatic test_both;
      latch(3, 3, 0);
      repeat (3) check_frame("both_win");
   endtask

   task automatic test_saturation;
      latch(0, 127, 0);
      repeat (2) check_frame("sat_127");
      latch(4, 15, 0);
      repeat (2) check_frame("score_4_15");
   endtask

   task automatic test_clr;
      latch(57, 42, 1);
      check_frame("clr_prio");
      @(negedge clk);
      p0 = 7'd9;
      p1 = 7'd9;
      check_frame("no_strobe");
   endtask

   task automatic test_reset_mid;
      int n;
      latch(5, 7, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (an_n === 8'hFF && n < 100);
      checks++;
      if (an_n === 8'hFF) begin errors++; $display("FAIL mid_drive got %h want not ff", an_n); end
      rst = 1'b1;
      m_s0 = 0;
      m_s1 = 0;
      #1;
      checks++;
      if ({an_n, seg_n} !== {8'hFF, 7'h7F}) begin
         errors++;
         $display("FAIL mid_reset got an_n=%h seg_n=%h want ff 7f", an_n, seg_n);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({an_n, seg_n} !== {8'hFE, 7'b1000000}) begin
         errors++;
         $display("FAIL restart_digit0 got an_n=%h seg_n=%b want fe 1000000", an_n, seg_n);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 200);
      checks++;
      if (n != ND * RD) begin errors++; $display("FAIL restart_tick got %0d want %0d", n, ND * RD); end
      check_frame("after_reset");
   endtask

   initial begin
      test_reset;
      test_scan;
      test_score;
      test_blink;
      test_both;
      test_saturation;
      test_clr;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
